// File: rtl/fsm_chk_pkg.sv
// Shared definitions for the FSM trace checker: the observed ring codes and
// the checker's own state encoding.
// Pure declarations; no logic, no latency, no flow control.
package fsm_chk_pkg;

    // Observed controller ring order: state1 -> state2 -> state3 -> state4 -> state1
    localparam logic [1:0] STATE1 = 2'd0;
    localparam logic [1:0] STATE2 = 2'd1;
    localparam logic [1:0] STATE3 = 2'd2;
    localparam logic [1:0] STATE4 = 2'd3;

    // Checker FSM: waiting for a first sample, tracking cleanly, or after an error
    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_TRACK = 2'd1,
        CHK_FAULT = 2'd2
    } chk_state_e;

    // Ring successor of a code, wrapping at the top (state4 -> state1 for 2-bit codes)
    function automatic logic [1:0] ring_next2(input logic [1:0] code);
        return code + 2'd1;
    endfunction

endpackage

// File: rtl/fsm_chk_stall_wdog.sv
// Dwell watchdog: counts consecutive valid samples holding one code, flags overstay.
// Latency: stall_o rises on the edge that samples the (STALL_MAX+1)-th identical sample.
// No backpressure; samples are consumed unconditionally, stall_o is sticky until clear/reset.
module fsm_chk_stall_wdog #(
    parameter int STALL_MAX = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic sample_i,
    input  logic restart_i,
    output logic stall_o
);

    // One extra count beyond STALL_MAX is enough to know the limit was exceeded
    localparam int DW = $clog2(STALL_MAX + 2);
    localparam logic [DW-1:0] DWELL_SAT = DW'(STALL_MAX + 1);
    localparam logic [DW-1:0] DWELL_LIM = DW'(STALL_MAX);

    logic [DW-1:0] dwell_q, dwell_d;
    logic          stall_q, stall_d;

    // Run-length of the current code: the first sample of a run counts as one
    always_comb begin
        dwell_d = dwell_q;
        stall_d = stall_q;
        if (clear_i) begin
            dwell_d = '0;
            stall_d = 1'b0;
        end else if (sample_i) begin
            if (restart_i) begin
                dwell_d = DW'(1);
            end else if (dwell_q != DWELL_SAT) begin
                dwell_d = dwell_q + DW'(1);
            end
            stall_d = stall_q | (dwell_d > DWELL_LIM);
        end
    end

    // Synchronous active-low reset of the dwell state
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dwell_q <= '0;
            stall_q <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            stall_q <= stall_d;
        end
    end

    assign stall_o = stall_q;

endmodule

// File: rtl/fsm_trace_checker.sv
// Watches a ring-ordered controller state code and flags illegal transitions.
// Latency: every output registered; err rises on the edge sampling the bad state_vld.
// No backpressure; optional dwell watchdog under FSM_TRACE_CHECKER_STALL_EN.
module fsm_trace_checker
    import fsm_chk_pkg::*;
#(
    parameter int STATE_W   = 2,
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_vld,
    input  logic               clear,
    output logic               err,
    output logic               err_sticky,
    output logic [STATE_W-1:0] err_from,
    output logic [STATE_W-1:0] err_to,
    output logic [CNT_W-1:0]   trans_cnt
`ifdef FSM_TRACE_CHECKER_STALL_EN
    ,
    output logic               stall
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // A zero or negative dwell limit would make stall meaningless
    if (STALL_MAX < 1) begin : g_bad_stall_max
        $error("fsm_trace_checker: STALL_MAX must be at least 1");
    end

    chk_state_e         chk_state_q, chk_state_d;
    logic [STATE_W-1:0] prev_q, prev_d;
    logic               err_q, err_d;
    logic               sticky_q, sticky_d;
    logic [STATE_W-1:0] from_q, from_d;
    logic [STATE_W-1:0] to_q, to_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [STATE_W-1:0] prev_succ;
    logic               changed;
    logic               legal;

    // Legality is hold-in-place or step to the ring successor (top code wraps to zero)
    always_comb begin
        prev_succ = prev_q + STATE_W'(1);
        changed   = (state_in != prev_q);
        legal     = !changed || (state_in == prev_succ);
    end

    // Checker FSM and status next-state; clear overrides any sample in the same cycle
    always_comb begin
        chk_state_d = chk_state_q;
        prev_d      = prev_q;
        err_d       = 1'b0;
        sticky_d    = sticky_q;
        from_d      = from_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        if (clear) begin
            chk_state_d = CHK_IDLE;
            prev_d      = '0;
            sticky_d    = 1'b0;
            from_d      = '0;
            to_d        = '0;
            cnt_d       = '0;
        end else if (state_vld) begin
            case (chk_state_q)
                CHK_IDLE: begin
                    // First sample only seeds history; nothing to compare against yet
                    prev_d      = state_in;
                    chk_state_d = CHK_TRACK;
                end
                CHK_TRACK, CHK_FAULT: begin
                    prev_d = state_in;
                    if (legal && changed && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!legal) begin
                        err_d = 1'b1;
                        // Only the first offence is recorded; later ones just pulse err
                        if (chk_state_q == CHK_TRACK) begin
                            sticky_d    = 1'b1;
                            from_d      = prev_q;
                            to_d        = state_in;
                            chk_state_d = CHK_FAULT;
                        end
                    end
                end
                default: begin
                    chk_state_d = CHK_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset discarding all history
    always_ff @(posedge CLK) begin
        if (!RST) begin
            chk_state_q <= CHK_IDLE;
            prev_q      <= '0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            from_q      <= '0;
            to_q        <= '0;
            cnt_q       <= '0;
        end else begin
            chk_state_q <= chk_state_d;
            prev_q      <= prev_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            from_q      <= from_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_from   = from_q;
    assign err_to     = to_q;
    assign trans_cnt  = cnt_q;

`ifdef FSM_TRACE_CHECKER_STALL_EN
    logic wd_sample;
    logic wd_restart;

    // A run restarts on the seeding sample and on any code change, legal or not
    always_comb begin
        wd_sample  = state_vld && !clear;
        wd_restart = (chk_state_q == CHK_IDLE) || changed;
    end

    fsm_chk_stall_wdog #(
        .STALL_MAX (STALL_MAX)
    ) u_stall_wdog (
        .clk_i     (CLK),
        .rst_n_i   (RST),
        .clear_i   (clear),
        .sample_i  (wd_sample),
        .restart_i (wd_restart),
        .stall_o   (stall)
    );
`endif

endmodule

// File: doc/fsm_trace_checker.md
FSM_TRACE_CHECKER -- requirements
Module: fsm_trace_checker

Interface
REQ-001 SHALL have parameter STATE_W, default 2: width of the observed state code.
REQ-002 SHALL have parameter CNT_W, default 8: width of the transition counter.
REQ-003 SHALL have parameter STALL_MAX, default 16: maximum number of consecutive valid samples allowed in one state.
REQ-004 SHALL have port CLK  in  1  the single clock; all logic samples on the rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port state_in  in  STATE_W  state code from the observed controller.
REQ-007 SHALL have port state_vld  in  1  state_in is valid this cycle.
REQ-008 SHALL have port clear  in  1  clears error, stall and counter status.
REQ-009 SHALL have port err  out  1  one-cycle pulse on an illegal transition.
REQ-010 SHALL have port err_sticky  out  1  held high from the first illegal transition until clear or reset.
REQ-011 SHALL have port err_from  out  STATE_W  code before the first illegal transition.
REQ-012 SHALL have port err_to  out  STATE_W  code after the first illegal transition.
REQ-013 SHALL have port trans_cnt  out  CNT_W  count of legal state changes.
REQ-014 SHALL have port stall  out  1  dwell limit exceeded; present only when the macro in REQ-027 is defined.

Function
REQ-015 SHALL use the ring order state1=0, state2=1, state3=2, state4=3.
REQ-016 SHALL treat a transition as legal when the new code equals the previous code, or equals (previous+1) mod 2^STATE_W; 3->0 wrap is legal.
REQ-017 SHALL implement a checker FSM with states IDLE, TRACK and FAULT.
REQ-018 IDLE: SHALL load the first valid sample as the previous code, make no legality check, and move to TRACK.
REQ-019 TRACK: on each valid sample, SHALL compare it with the previous code, then update the previous code.
REQ-020 On a legal change (new code differs from previous), SHALL increment trans_cnt, saturating at all-ones.
REQ-021 On an illegal sample, SHALL assert err for 1 cycle, set err_sticky, capture err_from/err_to, and move to FAULT.
REQ-022 FAULT: SHALL keep checking and pulsing err, and SHALL NOT overwrite err_from/err_to (the first error is retained).
REQ-023 All outputs SHALL be registered; err SHALL rise on the edge that samples the offending state_vld (1-cycle latency).
REQ-024 Cycles with state_vld=0 SHALL be ignored: no compare, no count, and no dwell advance.
REQ-025 clear=1 SHALL return the FSM to IDLE and zero all status outputs; a sample presented in the same cycle SHALL be discarded (clear wins).

Reset
REQ-026 While RST=0 at a clock edge, the block SHALL enter IDLE, with err=0, err_sticky=0, err_from=0, err_to=0, trans_cnt=0 and stall=0; reset mid-operation SHALL discard all history.

Configuration
REQ-027 With FSM_TRACE_CHECKER_STALL_EN defined, the block SHALL include a dwell counter that counts consecutive valid samples with an unchanged code.
REQ-028 With the macro defined, stall SHALL be set, and held until clear or reset, when the dwell count exceeds STALL_MAX; any code change SHALL zero the dwell count.
REQ-029 Without the macro, the stall port and the dwell counter SHALL be absent.

Structure
REQ-030 Package fsm_chk_pkg SHALL hold the state-code constants (state1..state4) and the checker-FSM state enum.
REQ-031 The dwell logic SHALL be a sub-module fsm_chk_stall_wdog, instantiated only under the macro in REQ-027.

Verification
REQ-032 Feed valid codes 0,1,2,3,0 -> trans_cnt=4, err never asserted.
REQ-033 Feed valid codes 0,2 -> err pulses 1 cycle, err_sticky=1, err_from=0, err_to=2; then feed 3,1 -> err pulses again, err_from/err_to unchanged.
REQ-034 Feed codes 1,1,1 with state_vld=0 interleaved, then 2 -> trans_cnt=1, no err.
REQ-035 Feed code 0 for 17 valid samples with STALL_MAX=16 and macro defined -> stall=1 on the 17th; a following clear -> stall=0, FSM in IDLE.
REQ-036 With CNT_W=2, feed 6 legal changes -> trans_cnt saturates at 3.
REQ-037 Assert RST=0 for 1 cycle in FAULT, then feed 2 -> all outputs 0 and 2 is accepted as the first sample with no err.
